// File: rtl/inst_rom_responder_if.sv
// rtl/inst_rom_responder_if.sv - fetch request/response and program-load bundle
interface inst_rom_responder_if #(
    parameter int ADDR_W = 10
);
    logic              ce;
    logic [31:0]       pc;
    logic              flush;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              addr_err;
    logic              stall_req;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;

    modport master (
        output ce, pc, flush, load_we, load_addr, load_data,
        input  inst, inst_valid, addr_err, stall_req
    );

    modport slave (
        input  ce, pc, flush, load_we, load_addr, load_data,
        output inst, inst_valid, addr_err, stall_req
    );
endinterface

// File: rtl/inst_rom_responder.sv
// rtl/inst_rom_responder.sv - instruction ROM responder with wait states, flush and load port
module inst_rom_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input logic                  clk,
    input logic                  rst,
    inst_rom_responder_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] pc_q, pc_nx;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    logic        fire;
    logic        clr;
    logic        stall;
    logic [31:0] rd_pc;
    logic        bad;
    logic [ADDR_W-1:0] idx;

    logic [31:0] inst_q;
    logic        valid_q;
    logic        err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            pc_q  <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pc_q  <= pc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_nx    = pc_q;
        case (state)
            IDLE: begin
                if (bus.ce && !bus.flush && WAIT_STATES > 0) begin
                    state_nx = BUSY;
                    cnt_nx   = 4'(WAIT_STATES - 1);
                    pc_nx    = bus.pc;
                end
            end
            BUSY: begin
                if (bus.flush)
                    state_nx = IDLE;
                else if (cnt != 4'd0)
                    cnt_nx = cnt - 4'd1;
                else
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // fire marks the edge that registers a completed fetch; stall holds the PC until then
    always_comb begin
        fire  = 1'b0;
        clr   = 1'b0;
        stall = 1'b0;
        rd_pc = bus.pc;
        case (state)
            IDLE: begin
                if (bus.ce && !bus.flush) begin
                    if (WAIT_STATES == 0)
                        fire = 1'b1;
                    else
                        stall = 1'b1;
                end else begin
                    clr = 1'b1;
                end
            end
            BUSY: begin
                if (!bus.flush) begin
                    if (cnt != 4'd0) begin
                        stall = 1'b1;
                    end else begin
                        fire  = 1'b1;
                        rd_pc = pc_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bad = (rd_pc[1:0] != 2'b00) || (rd_pc[31:ADDR_W+2] != '0);
    assign idx = rd_pc[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_q  <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= fire;
            err_q   <= fire & bad;
            if (fire)
                inst_q <= bad ? 32'd0 : mem[idx];
            else if (clr)
                inst_q <= 32'd0;
        end
    end

    // loads are independent of reset so boot code can fill the array while the core is held
    always_ff @(posedge clk) begin
        if (bus.load_we)
            mem[bus.load_addr] <= bus.load_data;
    end

    assign bus.inst       = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.addr_err   = err_q;
    assign bus.stall_req  = rst & stall;
endmodule

// File: tb/tb_inst_rom_responder.sv
// tb/tb_inst_rom_responder.sv - scoreboard bench for inst_rom_responder at three wait-state settings
module tb_inst_rom_responder;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NI    = 3;

    function automatic int wsf(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic [31:0]   pc = 32'd0;
    logic          flush = 1'b0;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = 32'd0;

    logic [NI-1:0] dv, de, ds;
    logic [31:0]   di [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        inst_rom_responder_if #(.ADDR_W(AW)) bus ();
        assign bus.ce        = ce;
        assign bus.pc        = pc;
        assign bus.flush     = flush;
        assign bus.load_we   = load_we;
        assign bus.load_addr = load_addr;
        assign bus.load_data = load_data;
        inst_rom_responder #(.ADDR_W(AW), .WAIT_STATES(wsf(g))) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign dv[g] = bus.inst_valid;
        assign de[g] = bus.addr_err;
        assign ds[g] = bus.stall_req;
        assign di[g] = bus.inst;
    end

    // reference: one outstanding request per responder, counted in edges to completion
    logic [31:0]   mem_m [DEPTH];
    logic          busy [NI];
    int            left [NI];
    logic [31:0]   addr [NI];
    logic [NI-1:0] ez;
    exp_t          sb [NI][$];

    int checks = 0;
    int failures = 0;

    initial begin
        for (int i = 0; i < NI; i++) begin
            busy[i] = 1'b0;
            left[i] = 0;
            addr[i] = 32'd0;
        end
        ez = '0;
    end

    function automatic exp_t resp(input logic [31:0] a);
        exp_t e;
        e.err  = (a % 4 != 0) || (a / 4 >= DEPTH);
        e.inst = 32'd0;
        if (!e.err) e.inst = mem_m[int'(a / 4)];
        return e;
    endfunction

    function automatic logic exp_stall(input int i);
        if (!rst || flush || wsf(i) == 0) return 1'b0;
        return busy[i] ? (left[i] > 1) : ce;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            ez[i] <= !rst;
            if (!rst || flush) begin
                busy[i] <= 1'b0;
            end else if (busy[i]) begin
                if (left[i] == 1) begin
                    sb[i].push_back(resp(addr[i]));
                    busy[i] <= 1'b0;
                end else begin
                    left[i] <= left[i] - 1;
                end
            end else if (ce) begin
                if (wsf(i) == 0) begin
                    sb[i].push_back(resp(pc));
                end else begin
                    busy[i] <= 1'b1;
                    left[i] <= wsf(i);
                    addr[i] <= pc;
                end
            end
        end
        if (load_we) mem_m[load_addr] <= load_data;
    end

    task automatic check(input logic ok, input string name, input int i,
                         input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s dut%0d(ws=%0d) actual=%h required=%h t=%0t", name, i, wsf(i), act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            check(ds[i] === exp_stall(i), "stall_req", i, {32'd0, ds[i]}, {32'd0, exp_stall(i)});
            if (dv[i] === 1'b1) begin
                check(sb[i].size() > 0, "unexpected_valid", i, 33'd1, 33'd0);
                if (sb[i].size() > 0) begin
                    e = sb[i].pop_front();
                    check(di[i] === e.inst, "inst", i, {1'b0, di[i]}, {1'b0, e.inst});
                    check(de[i] === e.err, "addr_err", i, {32'd0, de[i]}, {32'd0, e.err});
                end
            end else begin
                check(dv[i] === 1'b0 && sb[i].size() == 0, "missing_valid", i,
                      {32'd0, dv[i]}, {32'd0, sb[i].size() != 0});
                if (sb[i].size() > 0) void'(sb[i].pop_front());
                check(de[i] === 1'b0, "addr_err_idle", i, {32'd0, de[i]}, 33'd0);
            end
            if (ez[i]) check(di[i] === 32'd0 && dv[i] === 1'b0, "reset_inst", i, {1'b0, di[i]}, 33'd0);
        end
    end

    task automatic step(input logic r, input logic c, input logic [31:0] p, input logic f,
                        input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; ce = c; pc = p; flush = f;
        load_we = w; load_addr = a; load_data = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        ce  = 1'b1;
        // fill the whole array while reset is held with ce asserted
        for (int k = 0; k < DEPTH; k++)
            step(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, AW'(k), (k < 4) ? 32'h11 * (k + 1) : $urandom);
        step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, '0, 32'd0);

        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 32'(4 * k), 1'b0, 1'b0, '0, 32'd0);
        idle(4);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'd8, 1'b0, 1'b0, '0, 32'd0);
        idle(3);
        step(1'b1, 1'b1, 32'd4, 1'b0, 1'b0, '0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, '0, 32'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 32'd12, 1'b0, 1'b0, '0, 32'd0);
        idle(4);
        step(1'b1, 1'b1, 32'd6, 1'b0, 1'b0, '0, 32'd0);
        idle(4);
        step(1'b1, 1'b1, 32'd4 << AW, 1'b0, 1'b0, '0, 32'd0);
        idle(4);
        step(1'b1, 1'b1, 32'd4, 1'b0, 1'b1, AW'(1), 32'hAA);
        idle(4);
        step(1'b1, 1'b1, 32'd4, 1'b0, 1'b0, '0, 32'd0);
        idle(4);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] p;
            int r;
            r = $urandom_range(0, 9);
            p = 32'($urandom_range(0, DEPTH - 1)) * 4;
            if (r == 7)      p = p + 32'($urandom_range(1, 3));
            else if (r == 8) p = p | (32'($urandom_range(1, 255)) << (AW + 2));
            else if (r == 9) p = $urandom;
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, p,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 AW'($urandom_range(0, DEPTH - 1)), $urandom);
        end
        idle(8);
        @(negedge clk);
        #4;
        for (int i = 0; i < NI; i++)
            check(sb[i].size() == 0, "drain", i, 33'(sb[i].size()), 33'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
